cpu_run_ctrl: RTL

//  Run controller for the single-cycle RISC-V core. Loads a program into instruction

---
 rtl/cpu_run_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - program loader, reset sequencer and clock-enable gate for the single-cycle core
module cpu_run_ctrl #(
  parameter int unsigned IMEM_DEPTH   = 64,
  parameter int unsigned ADDR_W       = 6,
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned MAX_CYCLES   = 1000,
  parameter int unsigned RESET_CYCLES = 2,
  parameter logic [31:0] HALT_INSTR   = 32'h00000073
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              step_mode,
  input  logic              step,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [31:0]       load_data,
  input  logic              load_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_pc_reset,
  output logic              cpu_rf_reset,
  output logic              cpu_clk_en,
  input  logic [31:0]       cpu_instr,
  output logic              busy,
  output logic              halted,
  output logic              error,
  output logic [CNT_W-1:0]  cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_RESET_CPU = 3'd2,
    S_RUN       = 3'd3,
    S_HALT      = 3'd4
  } state_t;

  localparam int unsigned RST_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMEM_DEPTH - 1);
  localparam logic [CNT_W-1:0]  BUDGET    = CNT_W'(MAX_CYCLES);
  localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(RESET_CYCLES - 1);

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  ptr_q, ptr_d;
  logic [RST_W-1:0]   rst_cnt_q, rst_cnt_d;
  logic [CNT_W-1:0]   cycle_count_q, cycle_count_d;
  logic               error_q, error_d;
  logic               step_prev_q, step_prev_d;

  logic               xfer;
  logic               run_en;
  logic [CNT_W-1:0]   cnt_inc;

  // A step only fires on a fresh rising edge; step_prev_q tracks step in every state.
  always_comb begin
    xfer    = (state_q == S_LOAD) && load_valid;
    run_en  = (state_q == S_RUN) && (step_mode ? (step && !step_prev_q) : 1'b1);
    cnt_inc = (cycle_count_q == '1) ? cycle_count_q : cycle_count_q + CNT_W'(1);
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    rst_cnt_d     = rst_cnt_q;
    cycle_count_d = cycle_count_q;
    error_d       = error_q;
    step_prev_d   = step;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          ptr_d   = '0;
        end
      end
      S_LOAD: begin
        if (xfer) begin
          ptr_d = ptr_q + ADDR_W'(1);
          if (load_last) begin
            state_d       = S_RESET_CPU;
            rst_cnt_d     = '0;
            cycle_count_d = '0;
          end else if (ptr_q == LAST_ADDR) begin
            state_d = S_HALT;
            error_d = 1'b1;
          end
        end
      end
      S_RESET_CPU: begin
        if (rst_cnt_q == RST_LAST) begin
          state_d = S_RUN;
        end else begin
          rst_cnt_d = rst_cnt_q + RST_W'(1);
        end
      end
      S_RUN: begin
        if (run_en) begin
          cycle_count_d = cnt_inc;
          // A halt instruction takes priority over an exhausted budget in the same cycle.
          if (cpu_instr == HALT_INSTR) begin
            state_d = S_HALT;
          end else if ((MAX_CYCLES != 0) && (cnt_inc == BUDGET)) begin
            state_d = S_HALT;
            error_d = 1'b1;
          end
        end
      end
      S_HALT: begin
        if (start) begin
          state_d = S_LOAD;
          ptr_d   = '0;
          error_d = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      ptr_q         <= '0;
      rst_cnt_q     <= '0;
      cycle_count_q <= '0;
      error_q       <= 1'b0;
      step_prev_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      rst_cnt_q     <= rst_cnt_d;
      cycle_count_q <= cycle_count_d;
      error_q       <= error_d;
      step_prev_q   <= step_prev_d;
    end
  end

  assign load_ready   = (state_q == S_LOAD);
  assign imem_we      = xfer;
  assign imem_addr    = xfer ? ptr_q : '0;
  assign imem_wdata   = xfer ? load_data : '0;
  assign cpu_pc_reset = (state_q != S_RUN);
  assign cpu_rf_reset = (state_q != S_RUN);
  assign cpu_clk_en   = run_en;
  assign busy         = (state_q == S_LOAD) || (state_q == S_RESET_CPU) || (state_q == S_RUN);
  assign halted       = (state_q == S_HALT);
  assign error        = error_q;
  assign cycle_count  = cycle_count_q;

endmodule
